// File: rtl/y86_execute_stage_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// y86_execute_stage_if : E-stage inputs, pipeline control and E/M outputs
// Rev 1.0
// ---------------------------------------------------------------------------
interface y86_execute_stage_if #(
  parameter int WIDTH = 64
);
  logic [2:0]       E_stat;
  logic [3:0]       E_icode;
  logic [3:0]       E_ifun;
  logic [WIDTH-1:0] E_valA;
  logic [WIDTH-1:0] E_valB;
  logic [WIDTH-1:0] E_valC;
  logic [3:0]       E_dstE;
  logic [3:0]       E_dstM;
  logic [2:0]       m_stat;
  logic [2:0]       W_stat;
  logic             M_stall;
  logic             M_bubble;
  logic [WIDTH-1:0] e_valE;
  logic [3:0]       e_dstE;
  logic             e_Cnd;
  logic [2:0]       M_stat;
  logic [3:0]       M_icode;
  logic             M_Cnd;
  logic [WIDTH-1:0] M_valE;
  logic [WIDTH-1:0] M_valA;
  logic [3:0]       M_dstE;
  logic [3:0]       M_dstM;
  logic [2:0]       cc_out;

  modport slave (
    input  E_stat, E_icode, E_ifun, E_valA, E_valB, E_valC, E_dstE, E_dstM,
    input  m_stat, W_stat, M_stall, M_bubble,
    output e_valE, e_dstE, e_Cnd,
    output M_stat, M_icode, M_Cnd, M_valE, M_valA, M_dstE, M_dstM, cc_out
  );

  modport master (
    output E_stat, E_icode, E_ifun, E_valA, E_valB, E_valC, E_dstE, E_dstM,
    output m_stat, W_stat, M_stall, M_bubble,
    input  e_valE, e_dstE, e_Cnd,
    input  M_stat, M_icode, M_Cnd, M_valE, M_valA, M_dstE, M_dstM, cc_out
  );
endinterface
`default_nettype wire

// File: rtl/y86_execute_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// y86_execute_stage : Y86-64 ALU, registered CC, condition eval, E->M register
// Rev 1.0
// ---------------------------------------------------------------------------
module y86_execute_stage #(
  parameter int         WIDTH    = 64,
  parameter logic [3:0] REG_NONE = 4'hF
) (
  input  wire logic          clk,
  input  wire logic          rst,
  y86_execute_stage_if.slave bus
);
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [2:0] S_AOK = 3'd1;
  localparam logic [2:0] S_HLT = 3'd2;
  localparam logic [2:0] S_ADR = 3'd3;
  localparam logic [2:0] S_INS = 3'd4;

  localparam logic [WIDTH-1:0] C_NEG8 = {{(WIDTH-4){1'b1}}, 4'b1000};
  localparam logic [WIDTH-1:0] C_POS8 = {{(WIDTH-4){1'b0}}, 4'b1000};
  localparam logic [2:0]       C_CC_RESET = 3'b100;

  logic [WIDTH-1:0] alu_a, alu_b, alu_sum, alu_diff, val_e;
  logic             alu_of, op_bad, set_cc, cnd;
  logic [3:0]       dst_e;
  logic             cc_zf, cc_sf, cc_of;

  logic [2:0]       cc_d, cc_q;
  logic [2:0]       m_stat_d, m_stat_q;
  logic [3:0]       m_icode_d, m_icode_q;
  logic             m_cnd_d, m_cnd_q;
  logic [WIDTH-1:0] m_vale_d, m_vale_q;
  logic [WIDTH-1:0] m_vala_d, m_vala_q;
  logic [3:0]       m_dste_d, m_dste_q;
  logic [3:0]       m_dstm_d, m_dstm_q;

  function automatic logic stat_bad(input logic [2:0] s);
    return (s == S_ADR) || (s == S_INS) || (s == S_HLT);
  endfunction

  always_comb begin
    alu_a = '0;
    alu_b = '0;
    case (bus.E_icode)
      I_RRMOVQ, I_OPQ:             alu_a = bus.E_valA;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: alu_a = bus.E_valC;
      I_CALL, I_PUSHQ:             alu_a = C_NEG8;
      I_RET, I_POPQ:               alu_a = C_POS8;
      default:                     alu_a = '0;
    endcase
    case (bus.E_icode)
      I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL, I_PUSHQ, I_RET, I_POPQ: alu_b = bus.E_valB;
      default:                                                  alu_b = '0;
    endcase
  end

  always_comb begin
    alu_sum  = alu_b + alu_a;
    alu_diff = alu_b - alu_a;
    val_e    = alu_sum;
    alu_of   = 1'b0;
    op_bad   = (bus.E_icode == I_OPQ) && (bus.E_ifun > 4'd3);
    if (bus.E_icode == I_OPQ) begin
      case (bus.E_ifun)
        4'd0: begin
          val_e  = alu_sum;
          alu_of = (alu_a[WIDTH-1] == alu_b[WIDTH-1]) && (alu_sum[WIDTH-1] != alu_a[WIDTH-1]);
        end
        4'd1: begin
          val_e  = alu_diff;
          alu_of = (alu_b[WIDTH-1] != alu_a[WIDTH-1]) && (alu_diff[WIDTH-1] != alu_b[WIDTH-1]);
        end
        4'd2:    val_e = alu_b & alu_a;
        4'd3:    val_e = alu_b ^ alu_a;
        default: val_e = '0;
      endcase
    end
  end

  // A faulting instruction further down the pipe must not leave CC side effects.
  always_comb begin
    set_cc = (bus.E_icode == I_OPQ) && !op_bad && (bus.E_stat == S_AOK) &&
             !stat_bad(bus.m_stat) && !stat_bad(bus.W_stat);
    cc_d   = set_cc ? {(val_e == '0), val_e[WIDTH-1], alu_of} : cc_q;
  end

  always_comb begin
    {cc_zf, cc_sf, cc_of} = cc_q;
    case (bus.E_ifun)
      4'd0:    cnd = 1'b1;
      4'd1:    cnd = (cc_sf ^ cc_of) | cc_zf;
      4'd2:    cnd = cc_sf ^ cc_of;
      4'd3:    cnd = cc_zf;
      4'd4:    cnd = ~cc_zf;
      4'd5:    cnd = ~(cc_sf ^ cc_of);
      4'd6:    cnd = ~(cc_sf ^ cc_of) & ~cc_zf;
      default: cnd = 1'b0;
    endcase
    dst_e = ((bus.E_icode == I_RRMOVQ) && !cnd) ? REG_NONE : bus.E_dstE;
  end

  always_comb begin
    m_stat_d  = m_stat_q;
    m_icode_d = m_icode_q;
    m_cnd_d   = m_cnd_q;
    m_vale_d  = m_vale_q;
    m_vala_d  = m_vala_q;
    m_dste_d  = m_dste_q;
    m_dstm_d  = m_dstm_q;
    if (bus.M_bubble) begin
      m_stat_d  = S_AOK;
      m_icode_d = I_NOP;
      m_cnd_d   = 1'b0;
      m_vale_d  = '0;
      m_vala_d  = '0;
      m_dste_d  = REG_NONE;
      m_dstm_d  = REG_NONE;
    end else if (!bus.M_stall) begin
      m_stat_d  = op_bad ? S_INS : bus.E_stat;
      m_icode_d = bus.E_icode;
      m_cnd_d   = cnd;
      m_vale_d  = val_e;
      m_vala_d  = bus.E_valA;
      m_dste_d  = dst_e;
      m_dstm_d  = bus.E_dstM;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cc_q      <= C_CC_RESET;
      m_stat_q  <= S_AOK;
      m_icode_q <= I_NOP;
      m_cnd_q   <= 1'b0;
      m_vale_q  <= '0;
      m_vala_q  <= '0;
      m_dste_q  <= REG_NONE;
      m_dstm_q  <= REG_NONE;
    end else begin
      cc_q      <= cc_d;
      m_stat_q  <= m_stat_d;
      m_icode_q <= m_icode_d;
      m_cnd_q   <= m_cnd_d;
      m_vale_q  <= m_vale_d;
      m_vala_q  <= m_vala_d;
      m_dste_q  <= m_dste_d;
      m_dstm_q  <= m_dstm_d;
    end
  end

  assign bus.e_valE  = val_e;
  assign bus.e_dstE  = dst_e;
  assign bus.e_Cnd   = cnd;
  assign bus.M_stat  = m_stat_q;
  assign bus.M_icode = m_icode_q;
  assign bus.M_Cnd   = m_cnd_q;
  assign bus.M_valE  = m_vale_q;
  assign bus.M_valA  = m_vala_q;
  assign bus.M_dstE  = m_dste_q;
  assign bus.M_dstM  = m_dstm_q;
  assign bus.cc_out  = cc_q;
endmodule
`default_nettype wire

// File: tb/tb_y86_execute_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_y86_execute_stage : directed vectors, expected M state queued per cycle
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_y86_execute_stage;
  localparam logic [2:0] AOK = 3'd1;
  localparam logic [2:0] HLT = 3'd2;
  localparam logic [2:0] ADR = 3'd3;
  localparam logic [2:0] INS = 3'd4;
  localparam logic [3:0] NR  = 4'hF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  y86_execute_stage_if #(.WIDTH(64)) bus();
  y86_execute_stage #(.WIDTH(64), .REG_NONE(4'hF)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic        cnd;
    logic [63:0] vale;
    logic [63:0] vala;
    logic [3:0]  dste;
    logic [3:0]  dstm;
    logic [2:0]  cc;
  } exp_t;

  exp_t q[$];
  exp_t last;
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      chk("M_stat",  64'(bus.M_stat),  64'(mon_e.stat));
      chk("M_icode", 64'(bus.M_icode), 64'(mon_e.icode));
      chk("M_Cnd",   64'(bus.M_Cnd),   64'(mon_e.cnd));
      chk("M_valE",  bus.M_valE,       mon_e.vale);
      chk("M_valA",  bus.M_valA,       mon_e.vala);
      chk("M_dstE",  64'(bus.M_dstE),  64'(mon_e.dste));
      chk("M_dstM",  64'(bus.M_dstM),  64'(mon_e.dstm));
      chk("cc_out",  64'(bus.cc_out),  64'(mon_e.cc));
    end
  end

  // One vector per cycle: drive at negedge, check combinational outputs,
  // queue the M-register state expected after the next rising edge.
  task automatic step(input logic r, s, b, input logic [2:0] ms, ws,
                      input logic [3:0] ic, fn, input logic [63:0] va, vb, vc,
                      input logic [3:0] de, dm, input logic [63:0] ev, input logic ecnd,
                      input logic [3:0] edst, input logic [2:0] mst, input logic [2:0] ecc);
    exp_t e;
    @(negedge clk);
    rst = r; bus.M_stall = s; bus.M_bubble = b; bus.m_stat = ms; bus.W_stat = ws;
    bus.E_stat = AOK; bus.E_icode = ic; bus.E_ifun = fn;
    bus.E_valA = va; bus.E_valB = vb; bus.E_valC = vc; bus.E_dstE = de; bus.E_dstM = dm;
    #1;
    chk("e_valE", bus.e_valE, ev);
    chk("e_Cnd",  64'(bus.e_Cnd),  64'(ecnd));
    chk("e_dstE", 64'(bus.e_dstE), 64'(edst));
    if (r || b) begin
      e.stat = AOK; e.icode = 4'h1; e.cnd = 1'b0; e.vale = '0; e.vala = '0;
      e.dste = NR; e.dstm = NR;
    end else if (s) begin
      e = last;
    end else begin
      e.stat = mst; e.icode = ic; e.cnd = ecnd; e.vale = ev; e.vala = va;
      e.dste = edst; e.dstm = dm;
    end
    e.cc = ecc;
    last = e;
    q.push_back(e);
  endtask

  initial begin
    bus.E_stat = AOK; bus.E_icode = 4'h1; bus.E_ifun = 4'h0;
    bus.E_valA = '0; bus.E_valB = '0; bus.E_valC = '0; bus.E_dstE = NR; bus.E_dstM = NR;
    bus.m_stat = AOK; bus.W_stat = AOK; bus.M_stall = 1'b0; bus.M_bubble = 1'b0;
    last = '0;

    // reset
    step(1,0,0,AOK,AOK, 4'h1,4'h0, 64'h0,64'h0,64'h0, NR,NR, 64'h0,1'b1,NR, AOK,3'b100);
    // sub 3-5, then jl / jge on the resulting flags
    step(0,0,0,AOK,AOK, 4'h6,4'h1, 64'h5,64'h3,64'h0, 4'h2,NR, 64'hFFFF_FFFF_FFFF_FFFE,1'b1,4'h2, AOK,3'b010);
    step(0,0,0,AOK,AOK, 4'h7,4'h2, 64'h0,64'h0,64'h40, NR,NR, 64'h0,1'b1,NR, AOK,3'b010);
    step(0,0,0,AOK,AOK, 4'h7,4'h5, 64'h0,64'h0,64'h40, NR,NR, 64'h0,1'b0,NR, AOK,3'b010);
    // add overflow, then jl / jg
    step(0,0,0,AOK,AOK, 4'h6,4'h0, 64'h1,64'h7FFF_FFFF_FFFF_FFFF,64'h0, 4'h3,NR, 64'h8000_0000_0000_0000,1'b1,4'h3, AOK,3'b011);
    step(0,0,0,AOK,AOK, 4'h7,4'h2, 64'h0,64'h0,64'h0, NR,NR, 64'h0,1'b0,NR, AOK,3'b011);
    step(0,0,0,AOK,AOK, 4'h7,4'h6, 64'h0,64'h0,64'h0, NR,NR, 64'h0,1'b1,NR, AOK,3'b011);
    // xor to zero, then cmovne squashed / cmove kept
    step(0,0,0,AOK,AOK, 4'h6,4'h3, 64'h55,64'h55,64'h0, 4'h4,NR, 64'h0,1'b0,4'h4, AOK,3'b100);
    step(0,0,0,AOK,AOK, 4'h2,4'h4, 64'h77,64'h0,64'h0, 4'h3,NR, 64'h77,1'b0,NR, AOK,3'b100);
    step(0,0,0,AOK,AOK, 4'h2,4'h3, 64'h77,64'h0,64'h0, 4'h3,NR, 64'h77,1'b1,4'h3, AOK,3'b100);
    // CC suppression by m_stat, normal update, suppression by W_stat
    step(0,0,0,ADR,AOK, 4'h6,4'h0, 64'h2,64'h2,64'h0, 4'h5,NR, 64'h4,1'b1,4'h5, AOK,3'b100);
    step(0,0,0,AOK,AOK, 4'h6,4'h0, 64'h2,64'h2,64'h0, 4'h5,NR, 64'h4,1'b1,4'h5, AOK,3'b000);
    step(0,0,0,AOK,HLT, 4'h6,4'h1, 64'h4,64'h4,64'h0, 4'h5,NR, 64'h0,1'b0,4'h5, AOK,3'b000);
    // invalid OPq function
    step(0,0,0,AOK,AOK, 4'h6,4'h7, 64'h9,64'h9,64'h0, 4'h6,NR, 64'h0,1'b0,4'h6, INS,3'b000);
    // pushq, two stalled cycles with changing inputs, popq
    step(0,0,0,AOK,AOK, 4'hA,4'h0, 64'h33,64'h100,64'h0, 4'h4,NR, 64'hF8,1'b1,4'h4, AOK,3'b000);
    step(0,1,0,AOK,AOK, 4'hB,4'h0, 64'h11,64'h100,64'h0, 4'h4,4'h7, 64'h108,1'b1,4'h4, AOK,3'b000);
    step(0,1,0,AOK,AOK, 4'h3,4'h0, 64'h0,64'h0,64'h999, 4'h1,NR, 64'h999,1'b1,4'h1, AOK,3'b000);
    step(0,0,0,AOK,AOK, 4'hB,4'h0, 64'h11,64'h100,64'h0, 4'h4,4'h7, 64'h108,1'b1,4'h4, AOK,3'b000);
    // bubble still lets CC update
    step(0,0,1,AOK,AOK, 4'h6,4'h0, 64'h1,64'hFFFF_FFFF_FFFF_FFFE,64'h0, 4'h2,NR, 64'hFFFF_FFFF_FFFF_FFFF,1'b1,4'h2, AOK,3'b010);
    // reset wins over stall and over a CC-setting OPq
    step(1,1,0,AOK,AOK, 4'h6,4'h0, 64'h1,64'h2,64'h0, 4'h9,NR, 64'h3,1'b1,4'h9, AOK,3'b100);
    step(0,0,0,AOK,AOK, 4'h2,4'h0, 64'hAB,64'h0,64'h0, 4'h8,NR, 64'hAB,1'b1,4'h8, AOK,3'b100);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #3;
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expected entries left, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
